// File: rtl/gpr_regfile.sv
// GPR file: 32 x 64-bit entries, two registered read ports, two write ports.
// Latency: reads and writes take effect on the rising edge; read data appears one cycle after the enable.
// Backpressure: none; every enabled access completes in its cycle.
module gpr_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ren0,
  input  logic [4:0]  raddr0,
  output logic [63:0] rdata0,
  input  logic        ren1,
  input  logic [4:0]  raddr1,
  output logic [63:0] rdata1,
  input  logic        wen0,
  input  logic [4:0]  waddr0,
  input  logic [63:0] wdata0,
  input  logic        wen1,
  input  logic [4:0]  waddr1,
  input  logic [63:0] wdata1
);

  logic [63:0] mem_q [32];
  logic [63:0] mem_d [32];
  logic [63:0] rdata0_q, rdata0_d;
  logic [63:0] rdata1_q, rdata1_d;

  // Read ports sample the pre-write contents, so a same-edge write is not bypassed.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (ren0) rdata0_d = mem_q[raddr0];
    if (ren1) rdata1_d = mem_q[raddr1];
  end

  // Write port 1 is applied after port 0 so it wins on an address collision.
  always_comb begin
    for (int i = 0; i < 32; i++) mem_d[i] = mem_q[i];
    if (wen0) mem_d[waddr0] = wdata0;
    if (wen1) mem_d[waddr1] = wdata1;
  end

  // State update; reset clears all entries and both read registers immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) mem_q[i] <= mem_d[i];
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_gpr_regfile.sv
// Bench for gpr_regfile: directed scenarios plus random traffic against an array model.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
// The DUT has no backpressure, so every cycle is compared.
module tb_gpr_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren0, ren1, wen0, wen1;
  logic [4:0]  raddr0, raddr1, waddr0, waddr1;
  logic [63:0] wdata0, wdata1;
  logic [63:0] rdata0, rdata1;

  int total = 0;
  int bad = 0;

  logic [63:0] m_mem [32];
  logic [63:0] m_rd0, m_rd1;

  localparam logic [63:0] C5   = 64'h0123456789ABCDEF;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] STEP = 64'h0101010101010101;

  gpr_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_rd0 = '0;
    m_rd1 = '0;
  endtask

  // One clock cycle: drive, let the edge happen, advance the model, compare both ports.
  task automatic cyc(input logic e0, input logic [4:0] a0,
                     input logic e1, input logic [4:0] a1,
                     input logic w0, input logic [4:0] wa0, input logic [63:0] wd0,
                     input logic w1, input logic [4:0] wa1, input logic [63:0] wd1);
    ren0 = e0; raddr0 = a0; ren1 = e1; raddr1 = a1;
    wen0 = w0; waddr0 = wa0; wdata0 = wd0;
    wen1 = w1; waddr1 = wa1; wdata1 = wd1;
    @(posedge clk);
    if (rst_n) begin
      if (e0) m_rd0 = m_mem[a0];
      if (e1) m_rd1 = m_mem[a1];
      if (w0) m_mem[wa0] = wd0;
      if (w1) m_mem[wa1] = wd1;
    end else begin
      model_clear();
    end
    #1;
    check("rdata0", rdata0, m_rd0);
    check("rdata1", rdata1, m_rd1);
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    cyc(1'b1, a0, 1'b1, a1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic wr(input logic w0, input logic [4:0] wa0, input logic [63:0] wd0,
                    input logic w1, input logic [4:0] wa1, input logic [63:0] wd1);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, w0, wa0, wd0, w1, wa1, wd1);
  endtask

  initial begin
    ren0 = 0; ren1 = 0; wen0 = 0; wen1 = 0;
    raddr0 = 0; raddr1 = 0; waddr0 = 0; waddr1 = 0;
    wdata0 = 0; wdata1 = 0;
    rst_n = 1'b1;
    model_clear();
    #1 rst_n = 1'b0;
    @(negedge clk);
    // Enables and writes are ignored while reset is held.
    cyc(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, ONES, 1'b1, 5'd4, ONES);
    check("rst_rd0", rdata0, 64'd0);
    check("rst_rd1", rdata1, 64'd0);
    rst_n = 1'b1;

    // All entries read zero after reset, on both ports.
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check("zero0", rdata0, 64'd0);
      check("zero1", rdata1, 64'd0);
    end

    // Dual write then dual read.
    wr(1'b1, 5'd5, C5, 1'b1, 5'd31, ONES);
    rd(5'd5, 5'd31);
    check("r5", rdata0, C5);
    check("r31", rdata1, ONES);

    // Same-address write collision: port 1 wins.
    wr(1'b1, 5'd7, 64'h1111, 1'b1, 5'd7, 64'h2222);
    rd(5'd7, 5'd7);
    check("coll0", rdata0, 64'h2222);
    check("coll1", rdata1, 64'h2222);

    // Read during write returns the old value; next read sees the new one.
    wr(1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, 64'd0);
    cyc(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 64'hBB, 1'b0, 5'd0, 64'd0);
    check("rdw_old0", rdata0, 64'hAA);
    check("rdw_old1", rdata1, 64'hAA);
    rd(5'd3, 5'd3);
    check("rdw_new", rdata0, 64'hBB);

    // Enable low holds the last read value even as the address moves.
    rd(5'd5, 5'd31);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      check("hold0", rdata0, C5);
      check("hold1", rdata1, ONES);
    end

    // r0 is an ordinary register.
    wr(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0);
    rd(5'd0, 5'd0);
    check("r0", rdata0, 64'hDEAD);

    // Full sweep, two entries per cycle, then read back crosswise.
    for (int i = 0; i < 32; i += 2)
      wr(1'b1, 5'(i), 64'(i) * STEP, 1'b1, 5'(i + 1), 64'(i + 1) * STEP);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check("sweep0", rdata0, 64'(i) * STEP);
      check("sweep1", rdata1, 64'(31 - i) * STEP);
    end

    // Random traffic; narrow address window half the time to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] msk;
      msk = ($urandom_range(0, 1) == 1) ? 5'h03 : 5'h1F;
      cyc(1'($urandom), 5'($urandom) & msk, 1'($urandom), 5'($urandom) & msk,
          1'($urandom), 5'($urandom) & msk, {$urandom, $urandom},
          1'($urandom), 5'($urandom) & msk, {$urandom, $urandom});
    end

    // Asynchronous reset between edges clears outputs without a clock.
    wr(1'b1, 5'd30, ONES, 1'b1, 5'd31, 64'h5555);
    rd(5'd30, 5'd31);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd0", rdata0, 64'd0);
    check("arst_rd1", rdata1, 64'd0);
    model_clear();
    // Write while reset is asserted is lost.
    cyc(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 64'h77, 1'b1, 5'd6, 64'h88);
    rst_n = 1'b1;
    rd(5'd4, 5'd6);
    check("lost_wr0", rdata0, 64'd0);
    check("lost_wr1", rdata1, 64'd0);
    rd(5'd30, 5'd31);
    check("cleared30", rdata0, 64'd0);
    check("cleared31", rdata1, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
